// File: rtl/pll_mode_switcher_pkg.sv
// Shared state encoding, default C-counter words and pll_cfg register map for the PLL mode switcher.
package pll_mode_switcher_pkg;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;

   localparam logic [DATA_W-1:0] C_48MHZ        = 32'h0000_0A0A;
   localparam logic [DATA_W-1:0] C_50P5MHZ      = 32'h0002_0A09;
   localparam logic [ADDR_W-1:0] C_ADDR_DEF     = 6'h05;
   localparam logic [ADDR_W-1:0] START_ADDR_DEF = 6'h02;
   localparam logic [DATA_W-1:0] START_DATA     = 32'h0000_0001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_C,
      S_WR_START,
      S_BLANK,
      S_WAIT_LOCK,
      S_ERROR
   } sw_state_e;

   function automatic int cnt_width(input int max_val);
      if (max_val < 1) return 1;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pll_mode_switcher_if.sv
// Avalon-MM write-only master view of the pll_cfg reconfiguration port; waitrequest stalls the write.
interface pll_mode_switcher_if;
   import pll_mode_switcher_pkg::*;

   logic              mgmt_write;
   logic [ADDR_W-1:0] mgmt_address;
   logic [DATA_W-1:0] mgmt_writedata;
   logic              mgmt_waitrequest;

   modport master (
      output mgmt_write,
      output mgmt_address,
      output mgmt_writedata,
      input  mgmt_waitrequest
   );

   modport slave (
      input  mgmt_write,
      input  mgmt_address,
      input  mgmt_writedata,
      output mgmt_waitrequest
   );

endinterface

// File: rtl/pll_mode_switcher_mode_sync.sv
// Two-flop synchroniser plus optional run-length filter: q_vld once q_dat has been steady STABLE_CYC cycles.
// Latency 2 cycles to sync, STABLE_CYC more to validate; no backpressure.
module mode_sync #(
   parameter int W          = 1,
   parameter int STABLE_CYC = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_async,
   output logic [W-1:0] q_dat,
   output logic         q_vld
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_async;
         sync_q <= meta_q;
      end
   end

   if (STABLE_CYC <= 1) begin : g_pass
      assign q_dat = sync_q;
      assign q_vld = 1'b1;
   end else begin : g_filt
      localparam int CW = $clog2(STABLE_CYC + 1);

      logic [W-1:0]  last_q;
      logic [W-1:0]  last_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // cnt_q is the run length of last_q; any change restarts the run at one.
      always_comb begin
         last_d = sync_q;
         cnt_d  = cnt_q;
         if (sync_q != last_q) begin
            cnt_d = CW'(1);
         end else if (cnt_q != CW'(STABLE_CYC)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            last_q <= '0;
            cnt_q  <= '0;
         end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
         end
      end

      assign q_dat = last_q;
      assign q_vld = (cnt_q == CW'(STABLE_CYC));
   end

endmodule

// File: rtl/pll_mode_switcher.sv
// Reprograms the PLL C counter over pll_cfg for the requested mode, waits for lock with timeout/retry, reports via new_vmode.
// First mgmt_write one cycle after a valid request; each write is held stable while mgmt_waitrequest is high.
module pll_mode_switcher
   import pll_mode_switcher_pkg::*;
#(
   parameter int                        NUM_MODES    = 2,
   parameter int                        MW           = $clog2(NUM_MODES),
   parameter logic [NUM_MODES*32-1:0]   MODE_CDATA   = {C_50P5MHZ, C_48MHZ},
   parameter logic [ADDR_W-1:0]         C_ADDR       = C_ADDR_DEF,
   parameter logic [ADDR_W-1:0]         START_ADDR   = START_ADDR_DEF,
   parameter int                        STABLE_CYC   = 16,
   parameter int                        LOCK_BLANK   = 64,
   parameter int                        LOCK_TIMEOUT = 1048576,
   parameter int                        MAX_RETRY    = 3
) (
   input  logic                CLK_50M,
   input  logic                RESET,
   input  logic [MW-1:0]       mode_sel,
   input  logic                pll_locked,
   pll_mode_switcher_if.master mgmt,
   output logic                busy,
   output logic [MW-1:0]       cur_mode,
   output logic                new_vmode,
   output logic                error
);

   localparam int TMR_MAX = (LOCK_BLANK > LOCK_TIMEOUT) ? LOCK_BLANK : LOCK_TIMEOUT;
   localparam int TW      = cnt_width(TMR_MAX);
   localparam int RW      = cnt_width(MAX_RETRY);

   logic [MW-1:0] req_dat;
   logic          req_sync_vld;
   logic          req_vld;
   logic          lock_dat;
   logic          lock_vld;
   logic          lock_ok;

   mode_sync #(
      .W          (MW),
      .STABLE_CYC (STABLE_CYC)
   ) u_mode_sync (
      .clk     (CLK_50M),
      .rst     (RESET),
      .d_async (mode_sel),
      .q_dat   (req_dat),
      .q_vld   (req_sync_vld)
   );

   mode_sync #(
      .W          (1),
      .STABLE_CYC (1)
   ) u_lock_sync (
      .clk     (CLK_50M),
      .rst     (RESET),
      .d_async (pll_locked),
      .q_dat   (lock_dat),
      .q_vld   (lock_vld)
   );

   assign req_vld = req_sync_vld && (int'(req_dat) < NUM_MODES);
   assign lock_ok = lock_vld && lock_dat;

   sw_state_e       state_q, state_d;
   logic [MW-1:0]   target_q, target_d;
   logic [MW-1:0]   failed_q, failed_d;
   logic [MW-1:0]   cur_mode_q, cur_mode_d;
   logic            new_vmode_q, new_vmode_d;
   logic            error_q, error_d;
   logic            init_pending_q, init_pending_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            gap_q, gap_d;

   logic [MW-1:0]     cand;
   logic [DATA_W-1:0] cdata;
   logic              wr_vld;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_dat;

   assign cdata = MODE_CDATA[{target_q, 5'd0} +: 32];

   always_comb begin
      state_d        = state_q;
      target_d       = target_q;
      failed_d       = failed_q;
      cur_mode_d     = cur_mode_q;
      new_vmode_d    = new_vmode_q;
      error_d        = error_q;
      init_pending_d = init_pending_q;
      retry_d        = retry_q;
      tmr_d          = tmr_q;
      gap_d          = gap_q;
      cand           = req_vld ? req_dat : cur_mode_q;
      wr_vld         = 1'b0;
      wr_addr        = '0;
      wr_dat         = '0;
      busy           = 1'b1;

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (error_q && req_vld && (req_dat != failed_q)) begin
               error_d = 1'b0;
            end
            // A failed target stays parked until the request moves away from it.
            if ((init_pending_q || (req_vld && (req_dat != cur_mode_q))) &&
                !(error_q && (cand == failed_q))) begin
               busy     = 1'b1;
               target_d = cand;
               retry_d  = '0;
               error_d  = 1'b0;
               state_d  = S_WR_C;
            end
         end

         S_WR_C: begin
            wr_vld  = 1'b1;
            wr_addr = C_ADDR;
            wr_dat  = cdata;
            if (!mgmt.mgmt_waitrequest) begin
               gap_d   = 1'b1;
               state_d = S_WR_START;
            end
         end

         S_WR_START: begin
            wr_addr = START_ADDR;
            wr_dat  = START_DATA;
            if (gap_q) begin
               gap_d = 1'b0;
            end else begin
               wr_vld = 1'b1;
               if (!mgmt.mgmt_waitrequest) begin
                  tmr_d   = '0;
                  state_d = S_BLANK;
               end
            end
         end

         S_BLANK: begin
            if (tmr_q == TW'(LOCK_BLANK - 1)) begin
               tmr_d   = '0;
               state_d = S_WAIT_LOCK;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         S_WAIT_LOCK: begin
            if (lock_ok) begin
               cur_mode_d     = target_q;
               new_vmode_d    = ~new_vmode_q;
               error_d        = 1'b0;
               init_pending_d = 1'b0;
               state_d        = S_IDLE;
            end else if (tmr_q == TW'(LOCK_TIMEOUT - 1)) begin
               if (retry_q < RW'(MAX_RETRY)) begin
                  retry_d = retry_q + 1'b1;
                  state_d = S_WR_C;
               end else begin
                  error_d  = 1'b1;
                  failed_d = target_q;
                  state_d  = S_ERROR;
               end
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         S_ERROR: begin
            busy    = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_50M or posedge RESET) begin
      if (RESET) begin
         state_q        <= S_IDLE;
         target_q       <= '0;
         failed_q       <= '0;
         cur_mode_q     <= '0;
         new_vmode_q    <= 1'b0;
         error_q        <= 1'b0;
         init_pending_q <= 1'b1;
         retry_q        <= '0;
         tmr_q          <= '0;
         gap_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         target_q       <= target_d;
         failed_q       <= failed_d;
         cur_mode_q     <= cur_mode_d;
         new_vmode_q    <= new_vmode_d;
         error_q        <= error_d;
         init_pending_q <= init_pending_d;
         retry_q        <= retry_d;
         tmr_q          <= tmr_d;
         gap_q          <= gap_d;
      end
   end

   assign mgmt.mgmt_write     = wr_vld;
   assign mgmt.mgmt_address   = wr_addr;
   assign mgmt.mgmt_writedata = wr_dat;
   assign cur_mode            = cur_mode_q;
   assign new_vmode           = new_vmode_q;
   assign error               = error_q;

endmodule

// File: tb/tb_pll_mode_switcher.sv
// Bench for pll_mode_switcher: directed table, corner-case sequences and randomized mode changes vs a transaction model.
module tb_pll_mode_switcher;

   localparam int LOCK_BLANK = 64;

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [1:0]  mode;
      int          wait_n;
      bit          lock_en;
      int          npairs;
      logic [31:0] word;
      logic [1:0]  cur;
      bit          vm;
      bit          err;
      int          budget;
   } vec_t;

   localparam logic [31:0] CDATA [3] = '{32'h00000A0A, 32'h00020A09, 32'h00030B0B};

   logic       clk;
   logic       rst;
   logic [1:0] mode_sel;
   logic       pll_locked;
   logic       busy;
   logic [1:0] cur_mode;
   logic       new_vmode;
   logic       dut_error;

   pll_mode_switcher_if mgmt_if ();

   pll_mode_switcher #(
      .NUM_MODES    (3),
      .MODE_CDATA   ({32'h00030B0B, 32'h00020A09, 32'h00000A0A}),
      .STABLE_CYC   (16),
      .LOCK_BLANK   (LOCK_BLANK),
      .LOCK_TIMEOUT (100),
      .MAX_RETRY    (3)
   ) dut (
      .CLK_50M    (clk),
      .RESET      (rst),
      .mode_sel   (mode_sel),
      .pll_locked (pll_locked),
      .mgmt       (mgmt_if),
      .busy       (busy),
      .cur_mode   (cur_mode),
      .new_vmode  (new_vmode),
      .error      (dut_error)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   int   n_tests = 0;
   int   n_fail  = 0;
   int   wait_n;
   bit   lock_en;
   int   lock_dly;
   int   wr_hi;
   int   stab_err;
   wr_t  wr_q[$];

   int          wcnt;
   int          ltmr;
   bit          hold;
   logic [5:0]  ha;
   logic [31:0] hd;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_writes(input string tag, input int npairs, input logic [31:0] word);
      check({tag, "_nwr"}, 32'(wr_q.size()), 32'(2 * npairs));
      for (int j = 0; j < wr_q.size() && j < 2 * npairs; j++) begin
         check({tag, "_addr"}, 32'(wr_q[j].addr), (j % 2 == 0) ? 32'h5 : 32'h2);
         check({tag, "_data"}, wr_q[j].data, (j % 2 == 0) ? word : 32'h1);
      end
   endtask

   task automatic check_state(input string tag, input logic [1:0] cur, input bit vm,
                              input bit err, input bit bsy);
      check({tag, "_cur"}, 32'(cur_mode), 32'(cur));
      check({tag, "_vmode"}, 32'(new_vmode), 32'(vm));
      check({tag, "_error"}, 32'(dut_error), 32'(err));
      check({tag, "_busy"}, 32'(busy), 32'(bsy));
   endtask

   // pll_cfg slave and PLL model: stall each write wait_n cycles, record accepts, relock after a start write.
   initial begin : bus_model
      wr_t w;
      mgmt_if.mgmt_waitrequest = 1'b0;
      pll_locked = 1'b0;
      wcnt = 0; ltmr = 0; hold = 1'b0; ha = '0; hd = '0;
      forever begin
         @(negedge clk);
         if (ltmr > 0) begin
            ltmr--;
            if (ltmr == 0) pll_locked = 1'b1;
         end
         if (rst) begin
            mgmt_if.mgmt_waitrequest = 1'b0;
            wcnt = 0; hold = 1'b0; ltmr = 0;
         end else if (mgmt_if.mgmt_write) begin
            wr_hi++;
            if (hold && (mgmt_if.mgmt_address != ha || mgmt_if.mgmt_writedata != hd)) stab_err++;
            if (wcnt < wait_n) begin
               mgmt_if.mgmt_waitrequest = 1'b1;
               wcnt++;
               hold = 1'b1;
               ha = mgmt_if.mgmt_address;
               hd = mgmt_if.mgmt_writedata;
            end else begin
               mgmt_if.mgmt_waitrequest = 1'b0;
               wcnt = 0;
               hold = 1'b0;
               w.addr = mgmt_if.mgmt_address;
               w.data = mgmt_if.mgmt_writedata;
               wr_q.push_back(w);
               if (w.addr == 6'h02) begin
                  pll_locked = 1'b0;
                  ltmr = lock_en ? lock_dly : 0;
               end
            end
         end else begin
            mgmt_if.mgmt_waitrequest = 1'b0;
            wcnt = 0;
            hold = 1'b0;
         end
      end
   end

   initial begin : stim
      vec_t       tbl[6];
      logic [1:0] model_cur;
      bit         model_vm;
      int         m, g, glen, exp_n;

      tbl[0] = '{2'd0, 0, 1'b1, 1, 32'h00000A0A, 2'd0, 1'b1, 1'b0, 300};
      tbl[1] = '{2'd1, 5, 1'b1, 1, 32'h00020A09, 2'd1, 1'b0, 1'b0, 300};
      tbl[2] = '{2'd2, 0, 1'b0, 4, 32'h00030B0B, 2'd1, 1'b0, 1'b1, 1500};
      tbl[3] = '{2'd3, 0, 1'b1, 0, 32'h00000000, 2'd1, 1'b0, 1'b1, 300};
      tbl[4] = '{2'd0, 1, 1'b1, 1, 32'h00000A0A, 2'd0, 1'b1, 1'b0, 300};
      tbl[5] = '{2'd2, 2, 1'b1, 1, 32'h00030B0B, 2'd2, 1'b0, 1'b0, 300};

      rst = 1'b1; mode_sel = 2'd0; wait_n = 0; lock_en = 1'b1; lock_dly = LOCK_BLANK + 10;
      wr_hi = 0; stab_err = 0;
      repeat (3) @(negedge clk);
      check("rst_write", 32'(mgmt_if.mgmt_write), 32'h0);
      check("rst_addr", 32'(mgmt_if.mgmt_address), 32'h0);
      check("rst_data", mgmt_if.mgmt_writedata, 32'h0);
      check_state("rst", 2'd0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 6; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         wr_q.delete(); wr_hi = 0; stab_err = 0;
         wait_n = tbl[i].wait_n;
         lock_en = tbl[i].lock_en;
         if (i == 0) rst = 1'b0;
         else mode_sel = tbl[i].mode;
         repeat (tbl[i].budget) @(negedge clk);
         check_writes(tag, tbl[i].npairs, tbl[i].word);
         check({tag, "_wrcycles"}, 32'(wr_hi), 32'(2 * tbl[i].npairs * (tbl[i].wait_n + 1)));
         check({tag, "_hold"}, 32'(stab_err), 32'h0);
         check_state(tag, tbl[i].cur, tbl[i].vm, tbl[i].err, 1'b0);
      end

      // Request flips away and back while the first sequence waits for lock.
      wr_q.delete(); wait_n = 0; lock_en = 1'b1; lock_dly = LOCK_BLANK + 60;
      mode_sel = 2'd1;
      for (int k = 0; k < 400 && wr_q.size() < 2; k++) @(negedge clk);
      check("midreq_start", 32'(wr_q.size() >= 2), 32'h1);
      repeat (LOCK_BLANK + 5) @(negedge clk);
      mode_sel = 2'd0;
      repeat (30) @(negedge clk);
      mode_sel = 2'd1;
      repeat (300) @(negedge clk);
      check_writes("midreq", 1, 32'h00020A09);
      check_state("midreq", 2'd1, 1'b1, 1'b0, 1'b0);
      lock_dly = LOCK_BLANK + 10;

      // Glitches shorter than the stability window never start a sequence.
      wr_q.delete();
      for (int k = 0; k < 4; k++) begin
         mode_sel = 2'd0;
         repeat ($urandom_range(1, 12)) @(negedge clk);
         mode_sel = 2'd1;
         repeat (60) @(negedge clk);
      end
      check_writes("glitch", 0, 32'h0);
      check_state("glitch", 2'd1, 1'b1, 1'b0, 1'b0);

      // Reset in the middle of a stalled C write, then the init sequence runs again.
      wr_q.delete(); wait_n = 20;
      mode_sel = 2'd0;
      for (int k = 0; k < 100 && !mgmt_if.mgmt_write; k++) @(negedge clk);
      check("rstmid_wr_seen", 32'(mgmt_if.mgmt_write), 32'h1);
      repeat (3) @(negedge clk);
      #3 rst = 1'b1;
      #1 check("rstmid_drop", 32'(mgmt_if.mgmt_write), 32'h0);
      check_state("rstmid", 2'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      wait_n = 0; wr_q.delete(); wr_hi = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      check_writes("reinit", 1, 32'h00000A0A);
      check("reinit_wrcycles", 32'(wr_hi), 32'h2);
      check_state("reinit", 2'd0, 1'b1, 1'b0, 1'b0);

      // Randomized requests against a transaction-level model of mode/vmode.
      model_cur = 2'd0;
      model_vm  = 1'b1;
      for (int it = 0; it < 12; it++) begin
         string tag;
         tag = $sformatf("rnd%0d", it);
         m = $urandom_range(0, 3);
         g = $urandom_range(0, 3);
         glen = $urandom_range(1, 12);
         wait_n = $urandom_range(0, 3);
         wr_q.delete(); wr_hi = 0; stab_err = 0;
         mode_sel = 2'(g);
         repeat (glen) @(negedge clk);
         mode_sel = 2'(m);
         repeat (300) @(negedge clk);
         if (m < 3 && 2'(m) != model_cur) begin
            exp_n = 1;
            model_cur = 2'(m);
            model_vm = ~model_vm;
         end else begin
            exp_n = 0;
         end
         check_writes(tag, exp_n, (m < 3) ? CDATA[m] : 32'h0);
         check({tag, "_wrcycles"}, 32'(wr_hi), 32'(2 * exp_n * (wait_n + 1)));
         check({tag, "_hold"}, 32'(stab_err), 32'h0);
         check_state(tag, model_cur, model_vm, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
